divider_fp: RTL

DIVIDER_FP -- requirements
Module: divider_fp

---
 rtl/fp_pkg.sv | 41 ++++
 rtl/fp_classify.sv | 36 +++
 rtl/divider_fp.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// +------------------------------------------------------------------+
// | fp_pkg : shared binary32 field widths, constants and enums       |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_UNPACK    = 3'd1,
        ST_DIVIDE    = 3'd2,
        ST_NORMALIZE = 3'd3,
        ST_ROUND     = 3'd4,
        ST_DONE      = 3'd5
    } div_state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   man;
        fp_class_t        cls;
    } fp_unpacked_t;

endpackage

`default_nettype wire

// File: rtl/fp_classify.sv
// +------------------------------------------------------------------+
// | fp_classify : combinational binary32 unpack and classification   |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0]  op,
    output fp_unpacked_t fields
);

    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_frac;

    assign w_exp  = op[MAN_W +: EXP_W];
    assign w_frac = op[MAN_W-1:0];

    always_comb begin
        fields.sign = op[31];
        fields.exp  = w_exp;
        fields.man  = {1'b1, w_frac};
        fields.cls  = CLS_NORM;
        // Denormals are treated as zero, so exponent 0 alone decides the class.
        if (w_exp == '0) begin
            fields.cls = CLS_ZERO;
            fields.man = '0;
        end else if (w_exp == '1) begin
            fields.cls = (w_frac == '0) ? CLS_INF : CLS_NAN;
        end
    end

endmodule

`default_nettype wire

// File: rtl/divider_fp.sv
// +------------------------------------------------------------------+
// | divider_fp : multi-cycle IEEE-754 binary32 divider, RNE rounding  |
// | Optional IEEE flags output enabled by macro DIVIDER_FP_FLAGS_EN   |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module divider_fp
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Y,
    output logic        busy,
    output logic        ready
`ifdef DIVIDER_FP_FLAGS_EN
    ,
    output logic [3:0]  flags
`endif
);

    localparam logic [4:0] LAST_STEP = 5'd25;

    div_state_t         r_state;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic               r_hold;
    logic               r_sign;
    logic signed [9:0]  r_exp;
    logic [25:0]        r_rem;
    logic [23:0]        r_div;
    logic [25:0]        r_quo;
    logic [4:0]         r_cnt;
    logic [23:0]        r_mant;
    logic               r_guard;
    logic               r_sticky;

    fp_unpacked_t       w_ua;
    fp_unpacked_t       w_ub;

    fp_classify u_cls_a (.op(r_a), .fields(w_ua));
    fp_classify u_cls_b (.op(r_b), .fields(w_ub));

    logic        w_sign;
    logic        w_nan_res;
    logic        w_special;
    logic [31:0] w_special_y;

    assign w_sign    = w_ua.sign ^ w_ub.sign;
    assign w_special = (w_ua.cls != CLS_NORM) || (w_ub.cls != CLS_NORM);
    assign w_nan_res = (w_ua.cls == CLS_NAN) || (w_ub.cls == CLS_NAN)
                    || ((w_ua.cls == CLS_ZERO) && (w_ub.cls == CLS_ZERO))
                    || ((w_ua.cls == CLS_INF)  && (w_ub.cls == CLS_INF));

    always_comb begin
        w_special_y = {w_sign, 31'd0};
        if (w_nan_res) begin
            w_special_y = QNAN;
        end else if ((w_ub.cls == CLS_ZERO) || (w_ua.cls == CLS_INF)) begin
            w_special_y = {w_sign, POS_INF[30:0]};
        end
    end

    // Round-to-nearest-even on the normalized 24-bit mantissa.
    logic              w_inc;
    logic [24:0]       w_sum;
    logic signed [9:0] w_exp_rnd;
    logic [22:0]       w_frac_rnd;
    logic              w_ovf;
    logic              w_unf;
    logic [31:0]       w_round_y;

    assign w_inc      = r_guard & (r_sticky | r_mant[0]);
    assign w_sum      = {1'b0, r_mant} + {24'd0, w_inc};
    assign w_exp_rnd  = r_exp + $signed({9'd0, w_sum[24]});
    assign w_frac_rnd = w_sum[24] ? w_sum[23:1] : w_sum[22:0];
    assign w_ovf      = (w_exp_rnd >= 10'sd255);
    assign w_unf      = (w_exp_rnd <= 10'sd0);

    always_comb begin
        w_round_y = {r_sign, w_exp_rnd[7:0], w_frac_rnd};
        if (w_ovf) begin
            w_round_y = {r_sign, POS_INF[30:0]};
        end else if (w_unf) begin
            w_round_y = {r_sign, 31'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_hold   <= 1'b0;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_mant   <= '0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            Y        <= '0;
            busy     <= 1'b0;
            ready    <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_hold  <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= ST_UNPACK;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_UNPACK: begin
                    // Special results take a second UNPACK cycle, fixing their latency at 3.
                    if (w_special) begin
                        r_hold <= 1'b1;
                        if (r_hold) begin
                            Y       <= w_special_y;
                            ready   <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_sign  <= w_sign;
                        r_exp   <= $signed({2'b00, w_ua.exp}) - $signed({2'b00, w_ub.exp})
                                 + $signed(10'(BIAS));
                        r_rem   <= {2'b00, w_ua.man};
                        r_div   <= w_ub.man;
                        r_quo   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    if (r_rem >= {2'b00, r_div}) begin
                        r_rem <= (r_rem - {2'b00, r_div}) << 1;
                        r_quo <= {r_quo[24:0], 1'b1};
                    end else begin
                        r_rem <= r_rem << 1;
                        r_quo <= {r_quo[24:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == LAST_STEP) begin
                        r_state <= ST_NORMALIZE;
                    end
                end
                ST_NORMALIZE: begin
                    // Quotient bit 25 is the integer bit; a zero there means ratio < 1.
                    if (r_quo[25]) begin
                        r_mant   <= r_quo[25:2];
                        r_guard  <= r_quo[1];
                        r_sticky <= r_quo[0] | (|r_rem);
                    end else begin
                        r_mant   <= r_quo[24:1];
                        r_guard  <= r_quo[0];
                        r_sticky <= |r_rem;
                        r_exp    <= r_exp - 10'sd1;
                    end
                    r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    Y       <= w_round_y;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_DONE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DIVIDER_FP_FLAGS_EN
    logic       w_fin_special;
    logic       w_fin_round;
    logic [3:0] w_special_flags;

    assign w_fin_special   = (r_state == ST_UNPACK) && w_special && r_hold;
    assign w_fin_round     = (r_state == ST_ROUND);
    assign w_special_flags = {w_nan_res,
                              !w_nan_res && (w_ub.cls == CLS_ZERO) && (w_ua.cls == CLS_NORM),
                              2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= 4'd0;
        end else if (w_fin_special) begin
            flags <= w_special_flags;
        end else if (w_fin_round) begin
            flags <= {2'b00, w_ovf, w_unf};
        end
    end
`endif

endmodule

`default_nettype wire
